dct_outfifo: RTL

Output buffer and framing checker placed directly downstream of the DCT vector-rotation stage. The DCT output cannot be throttled because the FFT core inside the DCT always runs with its source side ready. This block absorbs whole DCT frames into on-chip RAM and re-presents them on an Avalon-ST source with real backpressure. It also validates the sop/eop framing against the frame length and forwards `fftpts` aligned to each output frame.

---
 rtl/dct_outfifo.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dct_outfifo.sv
// Frame buffer behind the DCT rotation stage: absorbs unthrottled DCT output into RAM,
// checks sop/eop framing against fftpts and replays frames on a backpressured Avalon-ST source.
`timescale 1ns/1ps
module dct_outfifo #(
    parameter int wData      = 16,
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sink_valid,
    output logic                    sink_ready,
    input  logic [1:0]              sink_error,
    input  logic                    sink_sop,
    input  logic                    sink_eop,
    input  logic signed [wData-1:0] sink_real,
    input  logic signed [wData-1:0] sink_imag,
    input  logic [11:0]             fftpts_in,
    output logic                    source_valid,
    input  logic                    source_ready,
    output logic [1:0]              source_error,
    output logic                    source_sop,
    output logic                    source_eop,
    output logic signed [wData-1:0] source_real,
    output logic signed [wData-1:0] source_imag,
    output logic [11:0]             fftpts_out,
    output logic                    ovf_sticky,
    output logic                    len_err,
    output logic                    orphan
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef struct packed {
        logic [11:0]             pts;
        logic [1:0]              err;
        logic                    sop;
        logic                    eop;
        logic signed [wData-1:0] re;
        logic signed [wData-1:0] im;
    } word_t;

    typedef enum logic {IDLE, FRAME} state_t;

    state_t                state;
    logic [11:0]           cnt;
    logic [11:0]           len;
    logic                  accept;
    logic                  wr_en;
    logic                  eop_bad;
    word_t                 word_p0;

    word_t                 mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    // occ counts every word not yet taken downstream; avail counts words still in RAM
    logic [DEPTH_LOG2:0]   occ;
    logic [DEPTH_LOG2:0]   avail;
    logic                  rd_en;
    logic                  vld_p1;
    word_t                 word_p1;
    logic                  load_p2;
    logic                  pop;

    function automatic logic [1:0] merge_err(input logic [1:0] err, input logic bad);
        return err | {1'b0, bad};
    endfunction

    function automatic logic len_mismatch(input logic [11:0] seen, input logic [11:0] want);
        return seen != want;
    endfunction

    assign sink_ready = (occ != FULL);
    assign accept     = sink_valid & sink_ready;
    assign wr_en      = accept & (sink_sop | (state == FRAME));

    always_comb begin
        eop_bad = 1'b0;
        if (accept && sink_eop) begin
            if (sink_sop)
                eop_bad = len_mismatch(12'd1, fftpts_in);
            else if (state == FRAME)
                eop_bad = len_mismatch(cnt + 12'd1, len);
        end
    end

    always_comb begin
        word_p0     = '0;
        word_p0.pts = sink_sop ? fftpts_in : 12'd0;
        word_p0.err = merge_err(sink_error, eop_bad);
        word_p0.sop = sink_sop;
        word_p0.eop = sink_eop;
        word_p0.re  = sink_real;
        word_p0.im  = sink_imag;
    end

    // Framing FSM: decides which accepted beats are stored and flags framing faults
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 12'd0;
            len     <= 12'd0;
            len_err <= 1'b0;
            orphan  <= 1'b0;
        end else begin
            len_err <= 1'b0;
            orphan  <= 1'b0;
            if (accept) begin
                if (sink_sop) begin
                    len     <= fftpts_in;
                    cnt     <= 12'd1;
                    state   <= sink_eop ? IDLE : FRAME;
                    len_err <= (state == FRAME) | eop_bad;
                end else if (state == FRAME) begin
                    if (sink_eop) begin
                        len_err <= eop_bad;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end else begin
                    orphan <= 1'b1;
                end
            end
        end
    end

    // Stage p0 -> p1: RAM write and registered RAM read
    assign pop     = source_valid & source_ready;
    assign load_p2 = vld_p1 & (~source_valid | source_ready);
    assign rd_en   = (avail != '0) & (~vld_p1 | load_p2);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= word_p0;
        if (rd_en)
            word_p1 <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            avail      <= '0;
            vld_p1     <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   avail <= avail + 1'b1;
                2'b01:   avail <= avail - 1'b1;
                default: avail <= avail;
            endcase
            case ({wr_en, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (rd_en)
                vld_p1 <= 1'b1;
            else if (load_p2)
                vld_p1 <= 1'b0;
            if (sink_valid && !sink_ready)
                ovf_sticky <= 1'b1;
        end
    end

    // Stage p1 -> p2: show-ahead source register, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            source_valid <= 1'b0;
            source_error <= 2'b00;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_real  <= '0;
            source_imag  <= '0;
            fftpts_out   <= 12'd0;
        end else if (load_p2) begin
            source_valid <= 1'b1;
            source_error <= word_p1.err;
            source_sop   <= word_p1.sop;
            source_eop   <= word_p1.eop;
            source_real  <= word_p1.re;
            source_imag  <= word_p1.im;
            if (word_p1.sop)
                fftpts_out <= word_p1.pts;
        end else if (pop) begin
            source_valid <= 1'b0;
        end
    end

endmodule
